// File: rtl/fpga_cfg_loader_if.sv
// Beat interface between the pad-side bitstream source and the configuration loader.
// A beat transfers on a rising clk edge where cfg_valid and cfg_ready are both high; the source holds cfg_data stable while cfg_valid is high and not yet accepted.
interface fpga_cfg_loader_if #(
  parameter int LANES = 1
);
  logic             cfg_valid;
  logic [LANES-1:0] cfg_data;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/fpga_cfg_loader.sv
// Multi-lane configuration bitstream loader: shifts beats into LANES fabric chains,
// checks a CRC-8 trailer and enables the fabric only after a good load.
module fpga_cfg_loader #(
  parameter int LANES     = 1,
  parameter int CHAIN_LEN = 256,
  parameter int CRC_EN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cfg_start,
  fpga_cfg_loader_if.slave cfg,
  output logic [LANES-1:0] chain_out,
  output logic             chain_en,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             fabric_en,
  output logic [2:0]       state_dbg
);

  localparam int BEATS  = CHAIN_LEN / LANES;
  localparam int TBEATS = 8 / LANES;
  // Very short chains can have fewer data beats than trailer beats; size for both.
  localparam int CMAX   = (BEATS > TBEATS) ? BEATS : TBEATS;
  localparam int CW     = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LAST_DATA  = CW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_TRAIL = CW'(TBEATS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    crc, crc_n, crc_upd;
  logic          done_q, err_q;
  logic          in_xfer, ready, start_go, acc;

  // Serial CRC-8 (poly 0x07), highest lane first within a beat.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [LANES-1:0] d);
    logic [7:0] r;
    r = c;
    for (int i = LANES - 1; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    crc_n    = crc;
    in_xfer  = (state == LOAD) || (state == CHECK);
    ready    = ena & in_xfer;
    start_go = ena & cfg_start;
    // A beat coinciding with a restart is dropped so the new load begins clean.
    acc      = ready & cfg.cfg_valid & ~cfg_start;
    crc_upd  = crc_step(crc, cfg.cfg_data);
    if (start_go) begin
      state_n = LOAD;
      cnt_n   = '0;
      crc_n   = 8'h00;
    end else if (acc) begin
      crc_n = crc_upd;
      if (state == LOAD) begin
        if (cnt == LAST_DATA) begin
          cnt_n   = '0;
          state_n = (CRC_EN != 0) ? CHECK : DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end else begin
        if (cnt == LAST_TRAIL) begin
          cnt_n   = '0;
          state_n = (crc_upd == 8'h00) ? DONE : ERR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      crc    <= 8'h00;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      crc    <= crc_n;
      done_q <= (state_n == DONE);
      err_q  <= (state_n == ERR);
    end
  end

  assign cfg.cfg_ready = ready;
  assign chain_en      = acc & (state == LOAD);
  assign chain_out     = chain_en ? cfg.cfg_data : '0;
  assign busy          = in_xfer;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign fabric_en     = done_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: four parameterisations side by side, a shared data bus,
// per-instance start/valid, and a chain_out scoreboard fed by the beat driver.
module tb_fpga_cfg_loader;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [3:0] start, vld;
  logic [7:0] dbus;

  wire  [3:0] rdy, cen, bsy, dn, er, fen;
  wire  [2:0] sd0, sd1, sd2, sd3;
  wire  [0:0] co0;
  wire  [7:0] co1;
  wire  [3:0] co2;
  wire  [1:0] co3;
  logic [7:0] co_x [4];

  int         lanes [4] = '{1, 8, 4, 2};
  int         pulses [4] = '{0, 0, 0, 0};
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_acc = 0;
  logic [7:0] exp_q [$];
  logic [255:0] stream;
  int         nbits;

  always #5 clk = ~clk;

  fpga_cfg_loader_if #(.LANES(1)) if0 ();
  fpga_cfg_loader_if #(.LANES(8)) if1 ();
  fpga_cfg_loader_if #(.LANES(4)) if2 ();
  fpga_cfg_loader_if #(.LANES(2)) if3 ();

  assign if0.cfg_valid = vld[0]; assign if0.cfg_data = dbus[0:0]; assign rdy[0] = if0.cfg_ready;
  assign if1.cfg_valid = vld[1]; assign if1.cfg_data = dbus[7:0]; assign rdy[1] = if1.cfg_ready;
  assign if2.cfg_valid = vld[2]; assign if2.cfg_data = dbus[3:0]; assign rdy[2] = if2.cfg_ready;
  assign if3.cfg_valid = vld[3]; assign if3.cfg_data = dbus[1:0]; assign rdy[3] = if3.cfg_ready;

  assign co_x[0] = {7'b0, co0};
  assign co_x[1] = co1;
  assign co_x[2] = {4'b0, co2};
  assign co_x[3] = {6'b0, co3};

  fpga_cfg_loader #(.LANES(1), .CHAIN_LEN(16), .CRC_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_start(start[0]), .cfg(if0.slave),
    .chain_out(co0), .chain_en(cen[0]), .busy(bsy[0]), .cfg_done(dn[0]),
    .cfg_err(er[0]), .fabric_en(fen[0]), .state_dbg(sd0));
  fpga_cfg_loader #(.LANES(8), .CHAIN_LEN(72), .CRC_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_start(start[1]), .cfg(if1.slave),
    .chain_out(co1), .chain_en(cen[1]), .busy(bsy[1]), .cfg_done(dn[1]),
    .cfg_err(er[1]), .fabric_en(fen[1]), .state_dbg(sd1));
  fpga_cfg_loader #(.LANES(4), .CHAIN_LEN(16), .CRC_EN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_start(start[2]), .cfg(if2.slave),
    .chain_out(co2), .chain_en(cen[2]), .busy(bsy[2]), .cfg_done(dn[2]),
    .cfg_err(er[2]), .fabric_en(fen[2]), .state_dbg(sd2));
  fpga_cfg_loader #(.LANES(2), .CHAIN_LEN(8), .CRC_EN(0)) u3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_start(start[3]), .cfg(if3.slave),
    .chain_out(co3), .chain_en(cen[3]), .busy(bsy[3]), .cfg_done(dn[3]),
    .cfg_err(er[3]), .fabric_en(fen[3]), .state_dbg(sd3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lmask(input int k);
    return (lanes[k] == 8) ? 8'hFF : 8'((1 << lanes[k]) - 1);
  endfunction

  // Reference CRC-8/0x07 over the recorded data stream, oldest bit first.
  function automatic logic [7:0] crc_model();
    logic [7:0] r;
    r = 8'h00;
    for (int i = nbits - 1; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ ((r[7] ^ stream[i]) ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Chain scoreboard: every chain_en pulse must match the oldest pending data beat.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst_n && cen[k]) begin
        pulses[k]++;
        if (exp_q.size() == 0) check_eq("chain_unexpected", 32'd1, 32'd0);
        else check_eq("chain_out", 32'(co_x[k]), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_beat(input int k, input logic [7:0] d, input bit is_data);
    int n;
    if (is_data) exp_q.push_back(d & lmask(k));
    dbus   = d;
    vld[k] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy[k]) break;
      n++;
      if (n >= 50) begin
        check_eq("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
    n_acc++;
  endtask

  task automatic send_data(input int k, input logic [7:0] d);
    stream = (stream << lanes[k]) | 256'(d & lmask(k));
    nbits += lanes[k];
    send_beat(k, d, 1'b1);
  endtask

  task automatic send_trailer(input int k, input logic [7:0] crc);
    for (int t = 0; t < 8 / lanes[k]; t++) begin
      send_beat(k, 8'(crc >> (8 - (t + 1) * lanes[k])) & lmask(k), 1'b0);
    end
  endtask

  task automatic do_start(input int k);
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    start[k]  = 1'b0;
    pulses[k] = 0;
    n_acc     = 0;
    stream    = '0;
    nbits     = 0;
    check_eq("start_busy", 32'(bsy[k]), 32'd1);
    check_eq("start_ready", 32'(rdy[k]), 32'd1);
  endtask

  initial begin
    logic [7:0] c;
    rst_n = 1'b0; ena = 1'b1; start = '0; vld = '0; dbus = '0;
    stream = '0; nbits = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(bsy), 32'd0);
    check_eq("rst_ready", 32'(rdy), 32'd0);
    check_eq("rst_chain_en", 32'(cen), 32'd0);
    check_eq("rst_done", 32'(dn), 32'd0);
    check_eq("rst_err", 32'(er), 32'd0);
    check_eq("rst_fabric", 32'(fen), 32'd0);
    check_eq("rst_state", 32'(sd0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single lane, good trailer 0x07 for data 0x0001.
    do_start(0);
    for (int i = 15; i >= 0; i--) send_data(0, 8'((16'h0001 >> i) & 16'h1));
    send_trailer(0, 8'h07);
    check_eq("l1_pulses", 32'(pulses[0]), 32'd16);
    check_eq("l1_done", 32'(dn[0]), 32'd1);
    check_eq("l1_fabric", 32'(fen[0]), 32'd1);
    check_eq("l1_err", 32'(er[0]), 32'd0);
    check_eq("l1_busy", 32'(bsy[0]), 32'd0);

    // Restart from DONE clears done/fabric; bad trailer 0x06 flags an error.
    do_start(0);
    check_eq("restart_done", 32'(dn[0]), 32'd0);
    check_eq("restart_fabric", 32'(fen[0]), 32'd0);
    for (int i = 15; i >= 0; i--) send_data(0, 8'((16'h0001 >> i) & 16'h1));
    send_trailer(0, 8'h06);
    check_eq("l1bad_err", 32'(er[0]), 32'd1);
    check_eq("l1bad_done", 32'(dn[0]), 32'd0);
    check_eq("l1bad_fabric", 32'(fen[0]), 32'd0);

    // Eight lanes: "123456789" with check value 0xF4, then with 0xF5.
    do_start(1);
    for (int i = 0; i < 9; i++) send_data(1, 8'h31 + 8'(i));
    send_trailer(1, 8'hF4);
    check_eq("l8_pulses", 32'(pulses[1]), 32'd9);
    check_eq("l8_beats", 32'(n_acc), 32'd10);
    check_eq("l8_done", 32'(dn[1]), 32'd1);
    do_start(1);
    for (int i = 0; i < 9; i++) send_data(1, 8'h31 + 8'(i));
    send_trailer(1, 8'hF5);
    check_eq("l8bad_err", 32'(er[1]), 32'd1);
    check_eq("l8bad_fabric", 32'(fen[1]), 32'd0);

    // Four lanes with a 5-cycle ena gap after beat 2, valid held high.
    do_start(2);
    send_data(2, 8'($urandom_range(0, 15)));
    send_data(2, 8'($urandom_range(0, 15)));
    dbus = 8'($urandom_range(0, 15)); vld[2] = 1'b1; ena = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("gap_ready", 32'(rdy[2]), 32'd0);
      check_eq("gap_chain_en", 32'(cen[2]), 32'd0);
    end
    @(posedge clk);
    #1;
    ena = 1'b1; vld[2] = 1'b0;
    send_data(2, 8'($urandom_range(0, 15)));
    send_data(2, 8'($urandom_range(0, 15)));
    send_trailer(2, crc_model());
    check_eq("l4_pulses", 32'(pulses[2]), 32'd4);
    check_eq("l4_done", 32'(dn[2]), 32'd1);

    // Abort after 7 beats; the beat presented with the restart must be dropped.
    do_start(0);
    for (int i = 0; i < 7; i++) send_data(0, 8'($urandom_range(0, 1)));
    dbus = 8'h01; vld[0] = 1'b1;
    do_start(0);
    vld[0] = 1'b0;
    for (int i = 0; i < 16; i++) send_data(0, 8'($urandom_range(0, 1)));
    send_trailer(0, crc_model());
    check_eq("abort_pulses", 32'(pulses[0]), 32'd16);
    check_eq("abort_done", 32'(dn[0]), 32'd1);

    // No CRC: DONE right after the 4th beat, no further beats taken.
    do_start(3);
    for (int i = 0; i < 4; i++) send_data(3, 8'($urandom_range(0, 3)));
    check_eq("nocrc_done", 32'(dn[3]), 32'd1);
    check_eq("nocrc_fabric", 32'(fen[3]), 32'd1);
    check_eq("nocrc_ready", 32'(rdy[3]), 32'd0);
    dbus = 8'($urandom_range(0, 3)); vld[3] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("nocrc_chain_en", 32'(cen[3]), 32'd0);
    end
    @(posedge clk);
    #1;
    vld[3] = 1'b0;
    check_eq("nocrc_pulses", 32'(pulses[3]), 32'd4);

    // Asynchronous reset in the middle of CHECK.
    do_start(0);
    for (int i = 0; i < 16; i++) send_data(0, 8'($urandom_range(0, 1)));
    c = crc_model();
    for (int t = 0; t < 3; t++) send_beat(0, 8'((c >> (7 - t)) & 8'h1), 1'b0);
    check_eq("chk_busy", 32'(bsy[0]), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(bsy), 32'd0);
    check_eq("arst_ready", 32'(rdy), 32'd0);
    check_eq("arst_fabric", 32'(fen), 32'd0);
    check_eq("arst_done", 32'(dn), 32'd0);
    check_eq("arst_err", 32'(er), 32'd0);
    check_eq("arst_state", 32'(sd0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Parametrised configuration-bitstream loader for the openfpga fabric inside the TinyTapeout user macro.
- Accepts a multi-lane bitstream from the pad interface and shifts it into LANES parallel configuration chains.
- Checks a CRC-8 trailer and gates fabric enable on a valid load.
- Successor to the fixed single-lane serial loader: adds selectable lane count, chain length, CRC check, abort/restart and pause via `ena`.

Parameters:
- LANES, 1: configuration lanes/chains loaded in parallel; legal values 1, 2, 4, 8.
- CHAIN_LEN, 256: bits per chain; must be a multiple of LANES.
- CRC_EN, 1: 1 = check the CRC-8 trailer; 0 = skip the trailer and go straight to DONE after the data.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; low pauses the loader.
- cfg_start  in  1  single-cycle pulse that begins or restarts a load.
- cfg_valid  in  1  beat valid.
- cfg_data  in  LANES  beat data, one bit per lane.
- cfg_ready  out  1  loader can accept a beat.
- chain_out  out  LANES  serial data to the fabric chains.
- chain_en  out  1  shift-enable to the fabric chains.
- busy  out  1  high in LOAD or CHECK.
- cfg_done  out  1  load complete and CRC good (sticky).
- cfg_err  out  1  CRC mismatch (sticky).
- fabric_en  out  1  fabric user logic enable.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, all outputs 0, beat counter and CRC register cleared.
  - Reset asserted mid-load abandons the load; fabric_en drops immediately.
- Beat handshake:
  - A beat is accepted on a clock edge with cfg_valid & cfg_ready.
  - cfg_ready = ena & (state==LOAD | state==CHECK).
- States:
  - IDLE -> LOAD on cfg_start & ena. This clears cfg_done, cfg_err, fabric_en, the counter and CRC=0x00.
  - LOAD: each accepted beat drives chain_out = cfg_data and chain_en = 1 for exactly that cycle (combinational from the handshake). chain_en = 0 otherwise.
  - LOAD exit: after CHAIN_LEN/LANES beats, go to CHECK (CRC_EN=1) or DONE (CRC_EN=0).
  - CHECK: accepts 8/LANES trailer beats; chain_en stays 0.
  - CHECK exit, on the edge after the last trailer beat:
    - CRC residue == 0x00 -> DONE: cfg_done=1, fabric_en=1.
    - otherwise -> ERR: cfg_err=1, fabric_en=0.
  - DONE / ERR: hold until cfg_start, which behaves exactly as from IDLE.
- CRC:
  - CRC-8, poly x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Bits within a beat are processed cfg_data[LANES-1] first, down to cfg_data[0].
  - The CRC covers data beats and trailer beats.
  - The trailer is sent MSB first. Trailer beat k carries crc[7-k*LANES -: LANES] with the higher bit on the higher lane.
  - A correct trailer yields residue 0.
- Latency: busy rises and cfg_ready is high one cycle after cfg_start.
- Boundary cases:
  - cfg_start during LOAD/CHECK aborts the load and restarts at beat 0 with CRC=0. A beat presented in that same cycle is ignored.
  - ena low: cfg_ready=0, chain_en=0, state, counter and CRC frozen. Resumes seamlessly when ena returns. cfg_start is ignored while ena is low.
  - cfg_valid in IDLE, DONE or ERR is ignored.
  - Beat counter is width $clog2(CHAIN_LEN/LANES+1) and never wraps. The last data beat moves to CHECK in the same edge.

Test Plan:
- LANES=1, CHAIN_LEN=16, CRC_EN=1:
  - data 0x0001 MSB first, trailer 0x07 -> 16 chain_en pulses with chain_out mirroring the data; cfg_done=1, fabric_en=1, cfg_err=0 one cycle after the last trailer beat.
  - same data, trailer 0x06 -> cfg_err=1, cfg_done=0, fabric_en=0.
- LANES=8, CHAIN_LEN=72:
  - beats are ASCII "123456789", trailer beat 0xF4 -> cfg_done=1 after 10 accepted beats.
  - trailer 0xF5 -> cfg_err=1.
- LANES=4, CHAIN_LEN=16:
  - drop ena for 5 cycles after beat 2 while holding cfg_valid -> no chain_en and cfg_ready=0 during the gap; the load completes correctly after ena returns.
- Abort/reset:
  - cfg_start after 7 of 16 beats, then a full good stream -> exactly 16 post-restart chain_en pulses, then cfg_done=1.
  - rst_n low mid-CHECK -> all outputs 0 asynchronously.
  - cfg_start from DONE -> fabric_en and cfg_done clear on the next edge.
- CRC_EN=0, LANES=2, CHAIN_LEN=8 -> DONE one cycle after the 4th beat; no trailer beats are accepted (cfg_ready=0 in DONE).
